// File: rtl/mux_select_arbiter.sv
// -----------------------------------------------------------------------------
// mux_select_arbiter
//
// Two-requester round-robin arbiter that owns the select line of the shared
// 2:1 mux path. A requester raises req, receives an exclusive grant, and
// releases it with a done pulse or by dropping req. Between two owners there
// is always one idle "gap" cycle with both grants low, so the mux output is
// never handed directly from one user to the other.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When defined, a grant that reaches HOLD_MAX consecutive cycles is
//   forcibly revoked if the other requester is waiting, and timeout pulses
//   for one cycle. When undefined, grants last until released and timeout
//   is tied to 0.
//
// Parameters:
//   HOLD_MAX  maximum consecutive grant cycles before forced rotation (2..15)
//   CNT_W     width of the hold counter, 2**CNT_W > HOLD_MAX
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-low reset
//   req1     requester 1 wants the mux (held high until done)
//   req2     requester 2 wants the mux
//   done1    requester 1 single-cycle release pulse
//   done2    requester 2 single-cycle release pulse
//   grant1   requester 1 owns the mux
//   grant2   requester 2 owns the mux
//   select   mux select: 0 = input1 path, 1 = input2 path
//   busy     grant1 | grant2, registered
//   timeout  one-cycle pulse when a grant is forcibly revoked
// -----------------------------------------------------------------------------
module mux_select_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req1,
    input  logic req2,
    input  logic done1,
    input  logic done2,
    output logic grant1,
    output logic grant2,
    output logic select,
    output logic busy,
    output logic timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Reject illegal parameter combinations at elaboration time.
    if (HOLD_MAX < 2 || HOLD_MAX > 15 || (2 ** CNT_W) <= HOLD_MAX) begin : g_param_check
        $error("mux_select_arbiter: HOLD_MAX must be 2..15 and fit in CNT_W bits");
    end

`ifdef ARB_TIMEOUT_EN
    // Counter value seen during the HOLD_MAX-th grant cycle.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
`endif

    state_t           state;
    state_t           arb_pick;
    logic             last_two;  // 1: requester 2 was the most recent owner
    logic [CNT_W-1:0] cnt;

    // Round-robin pick used from IDLE and GAP: on a tie the requester that
    // did not own the mux last wins.
    function automatic state_t arbitrate(input logic r1, input logic r2,
                                         input logic lt);
        if (r1 && r2) begin
            return lt ? GNT1 : GNT2;
        end else if (r1) begin
            return GNT1;
        end else if (r2) begin
            return GNT2;
        end
        return IDLE;
    endfunction

    assign arb_pick = arbitrate(req1, req2, last_two);

    // NOTE: all state and outputs update with non-blocking assignments so
    // every branch below reads the pre-edge values, never a half-updated mix.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant1   <= 1'b0;
            grant2   <= 1'b0;
            busy     <= 1'b0;
            select   <= 1'b0;
            last_two <= 1'b1;  // requester 1 wins the first tie
            cnt      <= '0;
`ifdef ARB_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE, GAP: begin
                    // select is not touched here, so it holds through GAP.
                    state <= arb_pick;
                    case (arb_pick)
                        GNT1: begin
                            grant1 <= 1'b1;
                            busy   <= 1'b1;
                            select <= 1'b0;
                            cnt    <= '0;
                        end
                        GNT2: begin
                            grant2 <= 1'b1;
                            busy   <= 1'b1;
                            select <= 1'b1;
                            cnt    <= '0;
                        end
                        default: ;
                    endcase
                end

                GNT1: begin
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                    // A done pulse and a dropped req in the same cycle
                    // collapse into this single release.
                    if (done1 || !req1) begin
                        state    <= GAP;
                        grant1   <= 1'b0;
                        busy     <= 1'b0;
                        last_two <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (cnt == HOLD_LAST && req2) begin
                        state    <= GAP;
                        grant1   <= 1'b0;
                        busy     <= 1'b0;
                        last_two <= 1'b0;
                        timeout  <= 1'b1;
                    end
`endif
                end

                GNT2: begin
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (done2 || !req2) begin
                        state    <= GAP;
                        grant2   <= 1'b0;
                        busy     <= 1'b0;
                        last_two <= 1'b1;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (cnt == HOLD_LAST && req1) begin
                        state    <= GAP;
                        grant2   <= 1'b0;
                        busy     <= 1'b0;
                        last_two <= 1'b1;
                        timeout  <= 1'b1;
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifndef ARB_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux_select_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_select_arbiter
//
// Directed testbench for mux_select_arbiter. Inputs are driven 1 time unit
// after each rising edge and outputs are sampled at the same point, so each
// sample reflects the edge just taken. Outputs are compared as the packed
// vector {grant1, grant2, select, busy, timeout}.
// -----------------------------------------------------------------------------
module tb_mux_select_arbiter;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic req1  = 1'b0;
    logic req2  = 1'b0;
    logic done1 = 1'b0;
    logic done2 = 1'b0;
    logic grant1, grant2, select, busy, timeout;

    logic [4:0] outs;
    assign outs = {grant1, grant2, select, busy, timeout};

    // Expected output patterns {grant1, grant2, select, busy, timeout}.
    localparam logic [4:0] P_OFF_S0 = 5'b00000;  // idle/gap, select=0
    localparam logic [4:0] P_OFF_S1 = 5'b00100;  // idle/gap, select=1
    localparam logic [4:0] P_G1     = 5'b10010;
    localparam logic [4:0] P_G2     = 5'b01110;
`ifdef ARB_TIMEOUT_EN
    localparam logic [4:0] P_TO_S0  = 5'b00001;  // forced gap after grant1
`endif

    int checks = 0;
    int errors = 0;

    mux_select_arbiter #(
        .HOLD_MAX(8),
        .CNT_W   (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req1   (req1),
        .req2   (req2),
        .done1  (done1),
        .done2  (done2),
        .grant1 (grant1),
        .grant2 (grant2),
        .select (select),
        .busy   (busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] got,
                         input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The two grants must never be high together.
    always @(negedge clk) begin
        check("mutex", {4'b0000, grant1 & grant2}, 5'b00000);
    end

    initial begin
        // ---------------- reset and idle ----------------
        #1;
        check("reset_state", outs, P_OFF_S0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("idle_after_reset_a", outs, P_OFF_S0);
        tick();
        check("idle_after_reset_b", outs, P_OFF_S0);

        // ---------------- single requester 2 ----------------
        req2 = 1'b1;
        tick();
        check("single_g2_first", outs, P_G2);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check("single_g2_hold", outs, P_G2);
        end
        done2 = 1'b1;
        req2  = 1'b0;  // done and req drop together: one release
        tick();
        done2 = 1'b0;
        check("single_release", outs, P_OFF_S1);
        tick();
        check("single_idle", outs, P_OFF_S1);

        // ---------------- asynchronous reset mid-GNT1 ----------------
        req1 = 1'b1;
        tick();
        check("g1_before_reset", outs, P_G1);
        #2 rst = 1'b0;
        #1;
        check("reset_mid_grant", outs, P_OFF_S0);
        req1 = 1'b0;
        repeat (3) tick();
        check("reset_held", outs, P_OFF_S0);
        rst = 1'b1;
        tick();
        check("idle_after_reset2_a", outs, P_OFF_S0);
        tick();
        check("idle_after_reset2_b", outs, P_OFF_S0);

        // ---------------- tie after reset, then fairness ----------------
        req1 = 1'b1;
        req2 = 1'b1;
        tick();
        check("tie_g1_first", outs, P_G1);
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        check("tie_gap", outs, P_OFF_S0);
        for (int k = 0; k < 4; k++) begin
            automatic logic owner2 = (k % 2 == 0);
            for (int c = 1; c <= 3; c++) begin
                tick();
                check(owner2 ? "fair_g2" : "fair_g1", outs, owner2 ? P_G2 : P_G1);
            end
            if (owner2) done2 = 1'b1;
            else        done1 = 1'b1;
            tick();
            done1 = 1'b0;
            done2 = 1'b0;
            check("fair_gap", outs, owner2 ? P_OFF_S1 : P_OFF_S0);
        end

        // ---------------- spurious done while the other owns ----------------
        req1 = 1'b0;
        tick();
        check("spur_g2", outs, P_G2);
        done1 = 1'b1;
        req1  = 1'b1;
        tick();
        done1 = 1'b0;
        check("spur_done1_ignored", outs, P_G2);
        tick();
        check("spur_g2_hold", outs, P_G2);
        req2 = 1'b0;
        tick();
        check("spur_req2_drop", outs, P_OFF_S1);
        tick();
        check("spur_regrant_g1", outs, P_G1);
        req1 = 1'b0;
        tick();
        check("spur_g1_release", outs, P_OFF_S0);
        tick();
        check("spur_idle", outs, P_OFF_S0);

        // ---------------- hold limit ----------------
        req1 = 1'b1;
        tick();
        check("to_g1_first", outs, P_G1);
        req2 = 1'b1;
        for (int c = 2; c <= 8; c++) begin
            tick();
            check("to_g1_hold", outs, P_G1);
        end
`ifdef ARB_TIMEOUT_EN
        tick();
        check("to_revoke", outs, P_TO_S0);
        tick();
        check("to_g2_after_gap", outs, P_G2);
        req1 = 1'b0;
        req2 = 1'b0;
        tick();
        check("to_g2_release", outs, P_OFF_S1);
`else
        for (int c = 9; c <= 20; c++) begin
            tick();
            check("to_g1_unlimited", outs, P_G1);
        end
        req1 = 1'b0;
        req2 = 1'b0;
        tick();
        check("to_g1_release", outs, P_OFF_S0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
